cross_bar_slave_mem: RTL
========================

# cross_bar_slave_mem

Word-addressed memory responder for the crossbar's slave-side request/acknowledge protocol. It attaches to one `slave_N_*` port group, accepts a single read or write per request, and inserts a configurable number of wait states. It returns a one-cycle registered `ack` pulse with `rdata` held stable afterwards. It serves as both the on-chip scratch RAM and the slave model in crossbar benches.

## Interface
- `DEPTH_LOG2`, default 8: memory holds 2^DEPTH_LOG2 32-bit words.
- `WAIT_CYCLES`, default 2: wait states between request capture and `ack`; legal range 0..15.
- `PCLK` input 1: clock; all logic on the rising edge.
- `PRESETN` input 1: reset, asynchronous, active-low.
- `req` input 1: request; held high by the initiator until `ack` is seen or the request is aborted.
- `cmd` input 1: 0 = read, 1 = write.
- `addr` input 32: byte address; word index is `addr[DEPTH_LOG2+1:2]`; all other bits are ignored (bit 31 is the crossbar's slave select).
- `wdata` input 32: write data.
- `ack` output 1: registered completion pulse, exactly one cycle high.
- `rdata` output 32: registered read data, valid from the `ack` cycle until the next read completes.

## Operation
- States: IDLE, WAIT, DONE.
- Wait counter `cnt` is 4 bits.
- Shadow registers hold `cmd`, word index and `wdata`.
- **IDLE:**
  - `req`=1 at an edge: capture `cmd`, word index and `wdata`; load `cnt`=WAIT_CYCLES; go to WAIT.
  - Otherwise stay in IDLE.
- **WAIT, `req`=0 at an edge:** abort. Go to IDLE; no write, no `ack`, `rdata` unchanged.
- **WAIT, `req`=1 and `cnt`≠0:** decrement `cnt`.
- **WAIT, `req`=1 and `cnt`=0:** complete.
  - Write: store the captured `wdata` at the captured index.
  - Read: `rdata` ← mem[index].
  - Set `ack` ← 1 and go to DONE.
- **DONE:**
  - `ack` ← 0 at the first edge.
  - Stay in DONE until `req` is sampled 0, then go to IDLE. The crossbar forces `req` low in its post-ack cycle, so this costs no extra cycle in the normal flow.
- Input changes after capture are ignored; the captured values are authoritative.
- Writes never modify `rdata`.
- Read-after-write to the same word returns the new data.
- Out-of-range address bits alias onto the array.
- **Reset (asserted at any time, including mid-WAIT or in DONE):**
  - Immediately: state IDLE, `ack`=0, `rdata`=0, `cnt`=0.
  - An in-flight write is dropped.
  - Memory contents are not reset.

## Timing
- `req` captured at edge t.
- `ack` high for the single cycle between edges t+1+WAIT_CYCLES and t+2+WAIT_CYCLES.
- `rdata` updates on the same edge `ack` rises. The crossbar samples `rdata` one edge later, when it is already stable.
- The write commits on the edge `ack` rises.
- `ack` is never high in two consecutive cycles, so the crossbar's rising-edge detector sees every completion.
- Minimum request-to-request spacing, measured from one capture edge to the next: WAIT_CYCLES+3 edges.
- No combinational path from any input to `ack` or `rdata`.

## Structure
- Shared `cross_bar_pkg` holds:
  - `CMD_READ`=1'b0, `CMD_WRITE`=1'b1;
  - `DATA_W`=32, `ADDR_W`=32;
  - the one-hot state localparams `IDLE`=3'b001, `WAIT`=3'b010, `DONE`=3'b100, reused by any future crossbar slave.
- One sub-module, `cross_bar_slave_ram`:
  - plain array with synchronous write and asynchronous read;
  - parameter `DEPTH_LOG2`;
  - no reset.
- The FSM, counter and shadow registers stay in the top.

## Test plan
- **Write then read, WAIT_CYCLES=2:**
  - Write 0xDEADBEEF to addr 0x0000_0010 with `req` captured at edge 10 → `ack` high in cycle 13 only.
  - Read of 0x10 → `rdata`=0xDEADBEEF from `ack` cycle onward; `rdata` unchanged by the write.
- **Zero wait states:**
  - WAIT_CYCLES=0, read captured at edge 5 → `ack` cycle 6.
  - Back-to-back reads of 0x0, 0x4 spaced 3 edges apart both complete with correct data.
- **Abort:**
  - Write 0x12345678 to 0x20, `req` dropped after one WAIT cycle → no `ack`.
  - Later read of 0x20 returns the prior contents.
- **Held `req`:**
  - Initiator keeps `req` high 4 cycles past `ack` → stays in DONE, single `ack` pulse, no second transaction.
- **Async reset mid-WAIT:**
  - `PRESETN` low between edges of a pending write to 0x30 → `ack`=0 and `rdata`=0 immediately.
  - Read of 0x30 after reset shows no write committed.
- **Crossbar integration:**
  - Two instances on slave_1/slave_2; both masters issue simultaneous writes to slave_1 (addr[31]=0).
  - → one master acked per arbitration turn, alternating, data in both locations correct.
  - Address 0x8000_0400 with DEPTH_LOG2=8 aliases to word 0.

Source files
------------

// File: rtl/cross_bar_pkg.sv
// Shared crossbar definitions: command encoding, bus widths and the one-hot
// state codes used by crossbar slave responders.
package cross_bar_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam logic [2:0] IDLE = 3'b001;
    localparam logic [2:0] WAIT = 3'b010;
    localparam logic [2:0] DONE = 3'b100;

endpackage

// File: rtl/cross_bar_slave_mem_if.sv
// Slave-side request/acknowledge port group of the crossbar.
interface cross_bar_slave_mem_if;
    import cross_bar_pkg::*;

    logic              req;
    logic              cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, cmd, addr, wdata, input ack, rdata);
    modport slave  (input req, cmd, addr, wdata, output ack, rdata);

endinterface

// File: rtl/cross_bar_slave_ram.sv
// Word array with synchronous write and asynchronous read; contents survive reset.
module cross_bar_slave_ram
    import cross_bar_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  PCLK,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata_c
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge PCLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/cross_bar_slave_mem.sv
// Word-addressed memory responder for one crossbar slave port: captures a
// request, waits WAIT_CYCLES, then returns a one-cycle registered ack.
module cross_bar_slave_mem
    import cross_bar_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                   PCLK,
    input  logic                   PRESETN,
    cross_bar_slave_mem_if.slave   bus
);

    localparam int unsigned CNT_W = 4;

    logic [2:0]            state_q;
    logic [2:0]            state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic                  sh_cmd_q;
    logic [DEPTH_LOG2-1:0] sh_idx_q;
    logic [DATA_W-1:0]     sh_wdata_q;
    logic                  ack_q;
    logic [DATA_W-1:0]     rdata_q;

    logic                  capture_c;
    logic                  dec_c;
    logic                  done_c;
    logic                  we_c;
    logic [DATA_W-1:0]     mem_rdata_c;
    logic                  unused_addr_bits;

    // Address bits outside the word index alias onto the array.
    assign unused_addr_bits = ^{bus.addr[ADDR_W-1:DEPTH_LOG2+2], bus.addr[1:0]};

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req) state_d = WAIT;
            WAIT:    if (!bus.req) state_d = IDLE;
                     else if (cnt_q == '0) state_d = DONE;
            DONE:    if (!bus.req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        capture_c = 1'b0;
        dec_c     = 1'b0;
        done_c    = 1'b0;
        case (state_q)
            IDLE:    capture_c = bus.req;
            WAIT: begin
                dec_c  = bus.req && (cnt_q != '0);
                done_c = bus.req && (cnt_q == '0);
            end
            default: ;
        endcase
    end

    assign we_c = done_c && (sh_cmd_q == CMD_WRITE);

    // Shadow registers make the captured request authoritative until completion.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            cnt_q      <= '0;
            sh_cmd_q   <= CMD_READ;
            sh_idx_q   <= '0;
            sh_wdata_q <= '0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            ack_q <= done_c;
            if (capture_c) begin
                cnt_q      <= CNT_W'(WAIT_CYCLES);
                sh_cmd_q   <= bus.cmd;
                sh_idx_q   <= bus.addr[DEPTH_LOG2+1:2];
                sh_wdata_q <= bus.wdata;
            end else if (dec_c) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (done_c && (sh_cmd_q == CMD_READ)) begin
                rdata_q <= mem_rdata_c;
            end
        end
    end

    cross_bar_slave_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .PCLK    (PCLK),
        .we      (we_c),
        .waddr   (sh_idx_q),
        .wdata   (sh_wdata_q),
        .raddr   (sh_idx_q),
        .rdata_c (mem_rdata_c)
    );

    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;

endmodule
